// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared load-type codes, FSM states and default widths for the writeback stage
package writeback_stage_pkg;

   localparam int DWIDTH_DEF   = 32;
   localparam int AWIDTH_DEF   = 5;
   localparam int MAX_WAIT_DEF = 15;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_stage_align.sv
// rtl/writeback_stage_align.sv - little-endian load alignment, extension and misalignment detection
module wb_load_align
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic [DWIDTH-1:0] data,
   input  logic [2:0]        load_type,
   input  logic [1:0]        byte_off,
   output logic [DWIDTH-1:0] aligned,
   output logic              misalign
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // pick the addressed byte/halfword, then extend according to the load type
   always_comb begin
      sel_byte = data[7:0];
      case (byte_off)
         2'd1:    sel_byte = data[15:8];
         2'd2:    sel_byte = data[23:16];
         2'd3:    sel_byte = data[31:24];
         default: sel_byte = data[7:0];
      endcase
      sel_half = byte_off[1] ? data[31:16] : data[15:0];

      aligned  = data;
      misalign = 1'b0;
      case (load_type)
         LD_LH: begin
            aligned  = {{(DWIDTH-16){sel_half[15]}}, sel_half};
            misalign = byte_off[0];
         end
         LD_LHU: begin
            aligned  = {{(DWIDTH-16){1'b0}}, sel_half};
            misalign = byte_off[0];
         end
         LD_LB: begin
            aligned  = {{(DWIDTH-8){sel_byte[7]}}, sel_byte};
         end
         LD_LBU: begin
            aligned  = {{(DWIDTH-8){1'b0}}, sel_byte};
         end
         default: begin
            aligned  = data;
            misalign = (byte_off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB stage with slow-memory wait/timeout; optional forwarding via WRITEBACK_FORWARD_EN
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH   = DWIDTH_DEF,
   parameter int AWIDTH   = AWIDTH_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              wb_i_ce,
   input  logic              wb_i_reg_wr,
   input  logic              wb_i_memtoreg,
   input  logic [2:0]        wb_i_load_type,
   input  logic [1:0]        wb_i_byte_off,
   input  logic [DWIDTH-1:0] wb_i_alu_result,
   input  logic [AWIDTH-1:0] wb_i_addr_rd,
   input  logic [DWIDTH-1:0] wb_i_mem_data,
   input  logic              wb_i_mem_ack,
   output logic              wb_o_stall,
   output logic              wb_o_reg_wr,
   output logic [AWIDTH-1:0] wb_o_addr_rd,
   output logic [DWIDTH-1:0] wb_o_data_rd,
   output logic              wb_o_ce,
   output logic              wb_o_err,
   output logic              wb_o_fwd_valid,
   output logic [AWIDTH-1:0] wb_o_fwd_addr,
   output logic [DWIDTH-1:0] wb_o_fwd_data
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   wb_state_t         state_q, state_d;
   logic [CW-1:0]     wait_cnt_q, wait_cnt_d;

   logic              cap_reg_wr_q;
   logic [2:0]        cap_load_type_q;
   logic [1:0]        cap_byte_off_q;
   logic [AWIDTH-1:0] cap_addr_q;

   logic              capture_en;
   logic              commit;
   logic              timeout;

   logic              sel_reg_wr;
   logic              sel_memtoreg;
   logic [2:0]        sel_load_type;
   logic [1:0]        sel_byte_off;
   logic [AWIDTH-1:0] sel_addr;

   logic [DWIDTH-1:0] aligned;
   logic              misalign;
   logic              commit_err;
   logic              commit_wr;
   logic [DWIDTH-1:0] commit_data;

   // while waiting, the captured fields describe the instruction, not the live MEM inputs
   always_comb begin
      if (state_q == ST_WAIT) begin
         sel_reg_wr    = cap_reg_wr_q;
         sel_memtoreg  = 1'b1;
         sel_load_type = cap_load_type_q;
         sel_byte_off  = cap_byte_off_q;
         sel_addr      = cap_addr_q;
      end else begin
         sel_reg_wr    = wb_i_reg_wr;
         sel_memtoreg  = wb_i_memtoreg;
         sel_load_type = wb_i_load_type;
         sel_byte_off  = wb_i_byte_off;
         sel_addr      = wb_i_addr_rd;
      end
   end

   wb_load_align #(.DWIDTH(DWIDTH)) u_align (
      .data      (wb_i_mem_data),
      .load_type (sel_load_type),
      .byte_off  (sel_byte_off),
      .aligned   (aligned),
      .misalign  (misalign)
   );

   // next-state, wait counter and commit/timeout decisions; an ack at the limit still commits
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      capture_en = 1'b0;
      commit     = 1'b0;
      timeout    = 1'b0;
      wb_o_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wb_i_ce) begin
               if (!wb_i_memtoreg || wb_i_mem_ack) begin
                  commit = 1'b1;
               end else begin
                  capture_en = 1'b1;
                  wb_o_stall = 1'b1;
                  state_d    = ST_WAIT;
                  wait_cnt_d = '0;
               end
            end
         end
         ST_WAIT: begin
            wb_o_stall = 1'b1;
            if (wb_i_mem_ack) begin
               commit     = 1'b1;
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
               timeout    = 1'b1;
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   assign commit_err  = commit & sel_memtoreg & misalign;
   assign commit_wr   = commit & sel_reg_wr & (sel_addr != '0) & ~commit_err;
   assign commit_data = sel_memtoreg ? aligned : wb_i_alu_result;

   // FSM state and wait counter
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // MEM/WB capture of a load that must wait for the memory
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         cap_reg_wr_q    <= 1'b0;
         cap_load_type_q <= LD_LW;
         cap_byte_off_q  <= 2'b00;
         cap_addr_q      <= '0;
      end else if (capture_en) begin
         cap_reg_wr_q    <= wb_i_reg_wr;
         cap_load_type_q <= wb_i_load_type;
         cap_byte_off_q  <= wb_i_byte_off;
         cap_addr_q      <= wb_i_addr_rd;
      end
   end

   // commit outputs: single-cycle pulses, address/data hold between commits
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wb_o_reg_wr  <= 1'b0;
         wb_o_ce      <= 1'b0;
         wb_o_err     <= 1'b0;
         wb_o_addr_rd <= '0;
         wb_o_data_rd <= '0;
      end else begin
         wb_o_reg_wr <= commit_wr;
         wb_o_ce     <= commit;
         wb_o_err    <= commit_err | timeout;
         if (commit) begin
            wb_o_addr_rd <= sel_addr;
            wb_o_data_rd <= commit_data;
         end
      end
   end

`ifdef WRITEBACK_FORWARD_EN
   // last real register write, kept for the decode-stage bypass
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wb_o_fwd_valid <= 1'b0;
         wb_o_fwd_addr  <= '0;
         wb_o_fwd_data  <= '0;
      end else if (commit_wr) begin
         wb_o_fwd_valid <= 1'b1;
         wb_o_fwd_addr  <= sel_addr;
         wb_o_fwd_data  <= commit_data;
      end
   end
`else
   assign wb_o_fwd_valid = 1'b0;
   assign wb_o_fwd_addr  = '0;
   assign wb_o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage against a transaction-level model
module tb_writeback_stage;

   localparam int MAX_WAIT = 15;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic        wb_i_ce, wb_i_reg_wr, wb_i_memtoreg, wb_i_mem_ack;
   logic [2:0]  wb_i_load_type;
   logic [1:0]  wb_i_byte_off;
   logic [31:0] wb_i_alu_result, wb_i_mem_data;
   logic [4:0]  wb_i_addr_rd;
   logic        wb_o_stall, wb_o_reg_wr, wb_o_ce, wb_o_err, wb_o_fwd_valid;
   logic [4:0]  wb_o_addr_rd, wb_o_fwd_addr;
   logic [31:0] wb_o_data_rd, wb_o_fwd_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   logic        exp_fwd_v;
   logic [4:0]  exp_fwd_a;
   logic [31:0] exp_fwd_d;

   writeback_stage #(.DWIDTH(32), .AWIDTH(5), .MAX_WAIT(MAX_WAIT)) dut (
      .wb_clk          (wb_clk),
      .wb_rst          (wb_rst),
      .wb_i_ce         (wb_i_ce),
      .wb_i_reg_wr     (wb_i_reg_wr),
      .wb_i_memtoreg   (wb_i_memtoreg),
      .wb_i_load_type  (wb_i_load_type),
      .wb_i_byte_off   (wb_i_byte_off),
      .wb_i_alu_result (wb_i_alu_result),
      .wb_i_addr_rd    (wb_i_addr_rd),
      .wb_i_mem_data   (wb_i_mem_data),
      .wb_i_mem_ack    (wb_i_mem_ack),
      .wb_o_stall      (wb_o_stall),
      .wb_o_reg_wr     (wb_o_reg_wr),
      .wb_o_addr_rd    (wb_o_addr_rd),
      .wb_o_data_rd    (wb_o_data_rd),
      .wb_o_ce         (wb_o_ce),
      .wb_o_err        (wb_o_err),
      .wb_o_fwd_valid  (wb_o_fwd_valid),
      .wb_o_fwd_addr   (wb_o_fwd_addr),
      .wb_o_fwd_data   (wb_o_fwd_data)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [2:0] lt, input logic [1:0] off);
      logic [31:0] h;
      logic [31:0] b;
      h = (w >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
      b = (w >> (int'(off) * 8)) & 32'h0000_00FF;
      case (lt)
         3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd2:    return h;
         3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         default: return w;
      endcase
   endfunction

   function automatic logic ref_misal(input logic [2:0] lt, input logic [1:0] off);
      case (lt)
         3'd1, 3'd2: return off[0];
         3'd3, 3'd4: return 1'b0;
         default:    return off != 2'b00;
      endcase
   endfunction

   task automatic check_outs(input logic e_ce, input logic e_wr, input logic e_err);
      check("reg_wr", wb_o_reg_wr, e_wr);
      check("ce", wb_o_ce, e_ce);
      check("err", wb_o_err, e_err);
      check("addr", wb_o_addr_rd, exp_addr);
      check("data", wb_o_data_rd, exp_data);
`ifdef WRITEBACK_FORWARD_EN
      check("fwd_valid", wb_o_fwd_valid, exp_fwd_v);
      check("fwd_addr", wb_o_fwd_addr, exp_fwd_a);
      check("fwd_data", wb_o_fwd_data, exp_fwd_d);
`else
      check("fwd_valid_off", wb_o_fwd_valid, 1'b0);
      check("fwd_addr_off", wb_o_fwd_addr, 5'd0);
      check("fwd_data_off", wb_o_fwd_data, 32'd0);
`endif
   endtask

   task automatic randomize_fields();
      wb_i_reg_wr     = 1'($urandom);
      wb_i_memtoreg   = 1'($urandom);
      wb_i_load_type  = 3'($urandom);
      wb_i_byte_off   = 2'($urandom);
      wb_i_alu_result = $urandom;
      wb_i_addr_rd    = 5'($urandom);
      wb_i_mem_data   = $urandom;
   endtask

   // one cycle with no instruction offered
   task automatic idle_cycle();
      wb_i_ce = 1'b0;
      randomize_fields();
      wb_i_mem_ack = 1'($urandom);
      #1 check("stall_idle", wb_o_stall, 1'b0);
      @(posedge wb_clk); #1;
      check_outs(1'b0, 1'b0, 1'b0);
   endtask

   // one instruction; for a load, d is the cycle (0 = accept cycle) on which the ack arrives
   task automatic do_instr(input logic rw, input logic m2r, input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] mem, input int d);
      int   last;
      logic commits;
      logic e_err, e_wr;
      commits = !m2r || (d <= MAX_WAIT);
      last    = !m2r ? 0 : ((d <= MAX_WAIT) ? d : MAX_WAIT);
      for (int k = 0; k <= last; k++) begin
         randomize_fields();
         if (k == 0) begin
            wb_i_ce         = 1'b1;
            wb_i_reg_wr     = rw;
            wb_i_memtoreg   = m2r;
            wb_i_load_type  = lt;
            wb_i_byte_off   = off;
            wb_i_alu_result = alu;
            wb_i_addr_rd    = rd;
         end else begin
            wb_i_ce = 1'($urandom);
         end
         wb_i_mem_ack = m2r ? (k == d) : 1'($urandom);
         if (m2r && k == d) wb_i_mem_data = mem;
         #1 check("stall", wb_o_stall, m2r && (k > 0 || d != 0));
         @(posedge wb_clk); #1;
         if (k != last) begin
            check_outs(1'b0, 1'b0, 1'b0);
         end else if (commits) begin
            e_err    = m2r && ref_misal(lt, off);
            e_wr     = rw && (rd != 5'd0) && !e_err;
            exp_addr = rd;
            exp_data = m2r ? ref_data(mem, lt, off) : alu;
            if (e_wr) begin
               exp_fwd_v = 1'b1;
               exp_fwd_a = rd;
               exp_fwd_d = exp_data;
            end
            check_outs(1'b1, e_wr, e_err);
         end else begin
            check_outs(1'b0, 1'b0, 1'b1);
         end
      end
   endtask

   task automatic model_reset();
      exp_addr  = '0;
      exp_data  = '0;
      exp_fwd_v = 1'b0;
      exp_fwd_a = '0;
      exp_fwd_d = '0;
   endtask

   initial begin
      int r, d;
      logic m2r;
      wb_rst = 1'b1;
      wb_i_ce = 1'b0;
      wb_i_mem_ack = 1'b0;
      randomize_fields();
      model_reset();
      repeat (2) @(posedge wb_clk);
      #1;
      check("reset_stall", wb_o_stall, 1'b0);
      check_outs(1'b0, 1'b0, 1'b0);
      wb_rst = 1'b0;

      do_instr(1'b1, 1'b0, 3'd0, 2'd0, 32'h1234, 5'd5, 32'h0, 0);
      check("alu_const", wb_o_data_rd, 32'h1234);
      do_instr(1'b1, 1'b1, 3'd3, 2'd3, 32'h0, 5'd7, 32'h80FF_7F01, 0);
      check("lb_const", wb_o_data_rd, 32'hFFFF_FF80);
      do_instr(1'b1, 1'b1, 3'd4, 2'd2, 32'h0, 5'd7, 32'h80FF_7F01, 0);
      check("lbu_const", wb_o_data_rd, 32'h0000_00FF);
      do_instr(1'b1, 1'b1, 3'd2, 2'd2, 32'h0, 5'd7, 32'h80FF_7F01, 0);
      check("lhu_const", wb_o_data_rd, 32'h0000_80FF);
      do_instr(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 5'd8, 32'hDEAD_BEEF, 4);
      check("slow_lw_const", wb_o_data_rd, 32'hDEAD_BEEF);
      idle_cycle();
      do_instr(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 5'd9, 32'hCAFE_F00D, MAX_WAIT + 1);
      idle_cycle();
      do_instr(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 5'd10, 32'h1357_2468, MAX_WAIT);
      check("limit_ack_const", wb_o_data_rd, 32'h1357_2468);
      do_instr(1'b1, 1'b0, 3'd0, 2'd0, 32'h55, 5'd0, 32'h0, 0);
      do_instr(1'b1, 1'b1, 3'd1, 2'd1, 32'h0, 5'd6, 32'hAABB_CCDD, 0);
      do_instr(1'b1, 1'b0, 3'd0, 2'd0, 32'd7, 5'd3, 32'h0, 0);
`ifdef WRITEBACK_FORWARD_EN
      check("fwd_r3", wb_o_fwd_data, 32'd7);
`endif
      do_instr(1'b1, 1'b0, 3'd0, 2'd0, 32'd9, 5'd4, 32'h0, 0);
`ifdef WRITEBACK_FORWARD_EN
      check("fwd_r4", wb_o_fwd_addr, 5'd4);
`endif

      // reset while a load is pending; a later ack must not produce a write
      wb_i_ce = 1'b1; wb_i_memtoreg = 1'b1; wb_i_reg_wr = 1'b1;
      wb_i_addr_rd = 5'd12; wb_i_load_type = 3'd0; wb_i_byte_off = 2'd0; wb_i_mem_ack = 1'b0;
      @(posedge wb_clk); #1;
      wb_i_ce = 1'b0;
      @(posedge wb_clk); #1;
      wb_rst = 1'b1;
      #1;
      model_reset();
      check("rst_mid_stall", wb_o_stall, 1'b0);
      check_outs(1'b0, 1'b0, 1'b0);
      wb_rst = 1'b0;
      repeat (3) idle_cycle();

      for (int i = 0; i < 200; i++) begin
         m2r = 1'($urandom);
         r = $urandom_range(0, 9);
         d = (r < 4) ? 0 : (r < 8) ? $urandom_range(1, MAX_WAIT) : $urandom_range(MAX_WAIT + 1, MAX_WAIT + 3);
         do_instr(1'($urandom), m2r, 3'($urandom), 2'($urandom), $urandom,
                  5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, d);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
